// File: rtl/time_count_bcd.sv
// time_count_bcd: BCD hh:mm:ss clock (24h/12h) with tick prescaler, checked preset, event strobes, alarm under TIME_COUNT_ALARM_EN
module time_count_bcd #(
  parameter int HOUR_MODE = 24,
  parameter int TICK_DIV = 1
) (
  input logic clk,
  input logic rst,
  input logic tick,
  input logic run,
  input logic load,
  input logic [7:0] load_h,
  input logic [7:0] load_m,
  input logic [7:0] load_s,
  input logic load_pm,
`ifdef TIME_COUNT_ALARM_EN
  input logic [7:0] alarm_h,
  input logic [7:0] alarm_m,
  input logic alarm_pm,
  input logic alarm_on,
  output logic alarm,
`endif
  output logic [3:0] s0,
  output logic [3:0] s1,
  output logic [3:0] m0,
  output logic [3:0] m1,
  output logic [3:0] h0,
  output logic [3:0] h1,
  output logic pm,
  output logic sec_pulse,
  output logic min_pulse,
  output logic hour_pulse,
  output logic day_wrap,
  output logic load_err
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam bit H12 = HOUR_MODE == 12;
  logic [PW-1:0] pre;
  logic adv, sw, mw, last, h11, ok, npm, ndw;
  logic [3:0] ns0, ns1, nm0, nm1, nh0, nh1;
  always_comb begin
    adv = run && tick && pre == PMAX;
    sw = s1 == 4'd5 && s0 == 4'd9;
    mw = sw && m1 == 4'd5 && m0 == 4'd9;
    h11 = h1 == 4'd1 && h0 == 4'd1;
    last = H12 ? h1 == 4'd1 && h0 == 4'd2 : h1 == 4'd2 && h0 == 4'd3;
    ns0 = s0 == 4'd9 ? 4'd0 : s0 + 4'd1;
    ns1 = sw ? 4'd0 : s0 == 4'd9 ? s1 + 4'd1 : s1;
    nm0 = !sw ? m0 : m0 == 4'd9 ? 4'd0 : m0 + 4'd1;
    nm1 = !sw ? m1 : mw ? 4'd0 : m0 == 4'd9 ? m1 + 4'd1 : m1;
    nh0 = !mw ? h0 : last ? (H12 ? 4'd1 : 4'd0) : h0 == 4'd9 ? 4'd0 : h0 + 4'd1;
    nh1 = !mw ? h1 : last ? 4'd0 : h0 == 4'd9 ? h1 + 4'd1 : h1;
    npm = H12 && mw && h11 ? !pm : pm;
    ndw = mw && (H12 ? h11 && pm : last);
    ok = load_s[3:0] <= 4'd9 && load_s[7:4] <= 4'd5 && load_m[3:0] <= 4'd9 && load_m[7:4] <= 4'd5 &&
         (H12 ? (load_h[7:4] == 4'd0 && load_h[3:0] != 4'd0 && load_h[3:0] <= 4'd9) ||
                (load_h[7:4] == 4'd1 && load_h[3:0] <= 4'd2)
              : load_h[7:4] <= 4'd2 && load_h[3:0] <= 4'd9 && (load_h[7:4] <= 4'd1 || load_h[3:0] <= 4'd3));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {h1, h0, m1, m0, s1, s0} <= H12 ? 24'h120000 : 24'h000000;
      pm <= 1'b0;
      pre <= '0;
      {sec_pulse, min_pulse, hour_pulse, day_wrap, load_err} <= 5'b0;
`ifdef TIME_COUNT_ALARM_EN
      alarm <= 1'b0;
`endif
    end else begin
      {sec_pulse, min_pulse, hour_pulse, day_wrap, load_err} <= 5'b0;
`ifdef TIME_COUNT_ALARM_EN
      alarm <= 1'b0;
`endif
      if (load) begin
        if (ok) begin
          {h1, h0, m1, m0, s1, s0} <= {load_h, load_m, load_s};
          pm <= H12 && load_pm;
          pre <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (run && tick) begin
        pre <= adv ? '0 : pre + 1'b1;
        if (adv) begin
          {h1, h0, m1, m0, s1, s0} <= {nh1, nh0, nm1, nm0, ns1, ns0};
          pm <= npm;
          sec_pulse <= 1'b1;
          min_pulse <= sw;
          hour_pulse <= mw;
          day_wrap <= ndw;
`ifdef TIME_COUNT_ALARM_EN
          alarm <= alarm_on && sw && {nh1, nh0, nm1, nm0} == {alarm_h, alarm_m} && (!H12 || npm == alarm_pm);
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_time_count_bcd.sv
// tb_time_count_bcd: scoreboard bench for a 24h/TICK_DIV=4 and a 12h/TICK_DIV=1 instance sharing stimulus
module tb_time_count_bcd;
  localparam logic [4:0] F_S = 5'b10000, F_M = 5'b01000, F_H = 5'b00100, F_D = 5'b00010, F_E = 5'b00001;
  typedef struct {
    string tag;
    bit sel;
    logic [29:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst, tick, run, load, load_pm;
  logic [7:0] load_h, load_m, load_s;
  logic [3:0] as0, as1, am0, am1, ah0, ah1, bs0, bs1, bm0, bm1, bh0, bh1;
  logic apm, asp, amp, ahp, adw, aerr, bpm, bsp, bmp, bhp, bdw, berr;
  logic [29:0] o24, o12;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  assign o24 = {ah1, ah0, am1, am0, as1, as0, apm, asp, amp, ahp, adw, aerr};
  assign o12 = {bh1, bh0, bm1, bm0, bs1, bs0, bpm, bsp, bmp, bhp, bdw, berr};
  time_count_bcd #(.HOUR_MODE(24), .TICK_DIV(4)) dut24 (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s), .load_pm(load_pm),
    .s0(as0), .s1(as1), .m0(am0), .m1(am1), .h0(ah0), .h1(ah1), .pm(apm),
    .sec_pulse(asp), .min_pulse(amp), .hour_pulse(ahp), .day_wrap(adw), .load_err(aerr)
  );
  time_count_bcd #(.HOUR_MODE(12), .TICK_DIV(1)) dut12 (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s), .load_pm(load_pm),
    .s0(bs0), .s1(bs1), .m0(bm0), .m1(bm1), .h0(bh0), .h1(bh1), .pm(bpm),
    .sec_pulse(bsp), .min_pulse(bmp), .hour_pulse(bhp), .day_wrap(bdw), .load_err(berr)
  );
  task automatic push(input string tag, input bit sel, input logic [23:0] t, input logic p, input logic [4:0] f);
    q.push_back('{tag, sel, {t, p, f}});
  endtask
  task automatic step();
    exp_t e;
    logic [29:0] obs;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      obs = e.sel ? o12 : o24;
      n_cmp++;
      assert (obs === e.v) else begin
        n_err++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask
  task automatic tk();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask
  task automatic ld(input logic [23:0] t, input logic p);
    load = 1'b1;
    {load_h, load_m, load_s} = t;
    load_pm = p;
    step();
    load = 1'b0;
  endtask
  initial begin
    rst = 1'b1; tick = 1'b0; run = 1'b0; load = 1'b1; load_pm = 1'b1;
    {load_h, load_m, load_s} = 24'h123456;
    push("rst_load_a", 0, 24'h000000, 1'b0, 5'b0);
    push("rst_load_b", 1, 24'h120000, 1'b0, 5'b0);
    step();
    rst = 1'b0; load = 1'b0; run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push("div_tick", 0, (i >= 8) ? 24'h2 : (i >= 4) ? 24'h1 : 24'h0, 1'b0, (i % 4 == 0) ? F_S : 5'b0);
      tk();
      push("div_idle", 0, (i >= 8) ? 24'h2 : (i >= 4) ? 24'h1 : 24'h0, 1'b0, 5'b0);
      step();
    end
    tk(); tk();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push("hold", 0, 24'h000002, 1'b0, 5'b0);
      tk();
    end
    run = 1'b1;
    push("resume_pre3", 0, 24'h000002, 1'b0, 5'b0);
    tk();
    push("resume_adv", 0, 24'h000003, 1'b0, F_S);
    tk();
    tk();
    push("ld_235959", 0, 24'h235959, 1'b0, 5'b0);
    ld(24'h235959, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push("ld_pre_clear", 0, 24'h235959, 1'b0, 5'b0);
      tk();
    end
    push("day_wrap24", 0, 24'h000000, 1'b0, F_S | F_M | F_H | F_D);
    tk();
    push("day_wrap24_idle", 0, 24'h000000, 1'b0, 5'b0);
    step();
    push("err_240000", 0, 24'h000000, 1'b0, F_E);
    ld(24'h240000, 1'b0);
    push("err_clear", 0, 24'h000000, 1'b0, 5'b0);
    step();
    tk(); tk(); tk();
    tick = 1'b1;
    push("ld_vs_tick", 0, 24'h102030, 1'b0, 5'b0);
    ld(24'h102030, 1'b0);
    tick = 1'b0;
    push("ld_vs_tick_pre", 0, 24'h102030, 1'b0, 5'b0);
    tk();
    rst = 1'b1;
    push("rst12", 1, 24'h120000, 1'b0, 5'b0);
    step();
    rst = 1'b0;
    push("b_ld_115959", 1, 24'h115959, 1'b0, 5'b0);
    ld(24'h115959, 1'b0);
    push("b_noon", 1, 24'h120000, 1'b1, F_S | F_M | F_H);
    tk();
    push("b_ld_125959", 1, 24'h125959, 1'b1, 5'b0);
    push("a_pm_const0", 0, 24'h125959, 1'b0, 5'b0);
    ld(24'h125959, 1'b1);
    push("b_one_pm", 1, 24'h010000, 1'b1, F_S | F_M | F_H);
    tk();
    push("b_ld_095959", 1, 24'h095959, 1'b0, 5'b0);
    ld(24'h095959, 1'b0);
    push("b_ten", 1, 24'h100000, 1'b0, F_S | F_M | F_H);
    tk();
    push("b_ld_115959pm", 1, 24'h115959, 1'b1, 5'b0);
    ld(24'h115959, 1'b1);
    push("b_midnight", 1, 24'h120000, 1'b0, F_S | F_M | F_H | F_D);
    tk();
    push("b_err_001000", 1, 24'h120000, 1'b0, F_E);
    push("a_ok_001000", 0, 24'h001000, 1'b0, 5'b0);
    ld(24'h001000, 1'b0);
    push("b_err_clear", 1, 24'h120000, 1'b0, 5'b0);
    step();
    ld(24'h235959, 1'b0);
    tk(); tk(); tk();
    rst = 1'b1; tick = 1'b1; load = 1'b1;
    push("rst_cascade_a", 0, 24'h000000, 1'b0, 5'b0);
    push("rst_cascade_b", 1, 24'h120000, 1'b0, 5'b0);
    step();
    rst = 1'b0; tick = 1'b0; load = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/time_count_bcd.md
TIME_COUNT_BCD -- requirements
Module: time_count_bcd

Interface
REQ-001 SHALL have parameter HOUR_MODE, default 24, allowed values 24 or 12: hour format.
REQ-002 SHALL have parameter TICK_DIV, default 1, integer >= 1: number of tick pulses per second.
REQ-003 SHALL have port clk  in  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port tick  in  1  time-base strobe, one clk cycle wide.
REQ-006 SHALL have port run  in  1  1 = count, 0 = hold time.
REQ-007 SHALL have port load  in  1  one-cycle strobe to preset the time.
REQ-008 SHALL have ports load_h, load_m, load_s  in  8 each  preset value, two BCD digits {tens,units}.
REQ-009 SHALL have port load_pm  in  1  preset PM flag; ignored when HOUR_MODE=24.
REQ-010 SHALL have ports s0, s1, m0, m1, h0, h1  out  4 each  BCD units/tens of seconds, minutes, hours.
REQ-011 SHALL have port pm  out  1  PM flag; constant 0 when HOUR_MODE=24.
REQ-012 SHALL have ports sec_pulse, min_pulse, hour_pulse, day_wrap  out  1 each  single-cycle event strobes.
REQ-013 SHALL have port load_err  out  1  single-cycle strobe: rejected preset.

Function
REQ-014 SHALL hold an internal prescaler 0..TICK_DIV-1; when run=1 and tick=1, prescaler increments, or wraps to 0 and advances time by one second when at TICK_DIV-1.
REQ-015 SHALL ignore tick and freeze the prescaler while run=0.
REQ-016 SHALL register all outputs; a second advance is visible on the cycle after the qualifying tick is sampled (latency 1).
REQ-017 SHALL keep every digit legal BCD: s0,m0 0-9; s1,m1 0-5; hours 00-23 (24h) or 01-12 (12h).
REQ-018 SHALL cascade carries: s 59->00 advances minutes; m 59->00 advances hours, all in the same advance.
REQ-019 SHALL in 24h mode wrap 23:59:59 -> 00:00:00.
REQ-020 SHALL in 12h mode step hours 12->01 at 12:59:59, and 11:59:59 -> 12:00:00 with pm toggled.
REQ-021 SHALL assert sec_pulse for exactly the first cycle a new second is visible; min_pulse when seconds wrapped to 00; hour_pulse when minutes wrapped to 00; day_wrap on 23:59:59->00:00:00 (24h) or 11:59:59 PM->12:00:00 AM (12h).
REQ-022 SHALL on load=1 accept the preset only if all six digits are legal per REQ-017; accepted: time and pm take preset next cycle, prescaler clears, no event strobes fire.
REQ-023 SHALL on illegal preset leave time, pm and prescaler unchanged and pulse load_err for one cycle.
REQ-024 SHALL give load priority over a same-cycle advance; that advance is discarded.
REQ-025 SHALL accept load regardless of run.

Reset
REQ-026 SHALL on rst=1 at a clock edge set time to 00:00:00 (24h) or 12:00:00 with pm=0 (12h), prescaler 0, all strobes and alarm 0.
REQ-027 SHALL give rst priority over load, tick and all other inputs, including mid-cascade.

Configuration
REQ-028 SHALL compile alarm logic only when macro TIME_COUNT_ALARM_EN is defined.
REQ-029 SHALL with TIME_COUNT_ALARM_EN add inputs alarm_h (8, BCD), alarm_m (8, BCD), alarm_pm (1, ignored in 24h), alarm_on (1), and output alarm (1).
REQ-030 SHALL with TIME_COUNT_ALARM_EN pulse alarm for one cycle, coincident with sec_pulse, when an advance produces hh:mm:00 equal to alarm_h:alarm_m (and pm=alarm_pm in 12h) while alarm_on=1; loads never trigger alarm.
REQ-031 SHALL without TIME_COUNT_ALARM_EN omit those ports and logic entirely; all other behaviour identical.

Verification
REQ-032 SHALL cover: 24h, TICK_DIV=4, reset then 8 ticks with run=1 -> time 00:00:02, sec_pulse twice, each 1 cycle after the 4th/8th tick.
REQ-033 SHALL cover: 24h, load 23:59:59 then one second -> 00:00:00 with sec_pulse, min_pulse, hour_pulse, day_wrap all high the same single cycle.
REQ-034 SHALL cover: 12h, load 11:59:59 pm=0 then one second -> 12:00:00 pm=1, day_wrap=0; load 12:59:59 pm=1 then one second -> 01:00:00 pm=1.
REQ-035 SHALL cover: load 24:00:00 (24h) or 00:10:00 (12h) -> load_err one cycle, time unchanged; load concurrent with qualifying tick -> preset value, no sec_pulse.
REQ-036 SHALL cover: run=0 for 10 ticks -> time and prescaler unchanged; rst asserted with load=1 -> reset values.
REQ-037 SHALL cover with TIME_COUNT_ALARM_EN: alarm 07:30, alarm_on=1, load 07:29:59, one second -> alarm one cycle; same with alarm_on=0 -> alarm stays 0.
